// File: rtl/seg7_scan4_if.sv
// Bus between a digit source and the seg7_scan4 display driver: the BCD
// snapshot controls flow in, the multiplexed segment/anode drive flows out.
interface seg7_scan4_if;
  logic        en;
  logic        latch;
  logic [15:0] bcd;
  logic [3:0]  dp;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        dp_out;
  logic [3:0]  an;
  logic [1:0]  digit_idx;

  // Digit source side: drives controls and digits, observes the display drive.
  modport master (
    output en, latch, bcd, dp, blank_lz,
    input  seg, dp_out, an, digit_idx
  );

  // Display driver side.
  modport slave (
    input  en, latch, bcd, dp, blank_lz,
    output seg, dp_out, an, digit_idx
  );
endinterface

// File: rtl/seg7_scan4.sv
// Four-digit time-multiplexed 7-segment driver. Digits are captured into a
// snapshot on latch so a scan never mixes old and new values; a prescaler
// sets the per-digit dwell, and segment/anode/dp drive is registered.
module seg7_scan4 #(
  parameter int SCAN_DIV     = 50000,
  parameter bit COMMON_ANODE = 1'b1
) (
  input logic          clk,
  input logic          clr,
  seg7_scan4_if.slave  bus
);

  // SCAN_DIV == 1 still needs a 1-bit counter so the compare stays legal.
  localparam int                DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
  // XOR mask that turns internal active-high drive into the pin polarity.
  localparam logic [6:0]        SEG_INV  = {7{COMMON_ANODE}};
  localparam logic [3:0]        AN_INV   = {4{COMMON_ANODE}};

  logic [15:0]      snap_bcd_q, snap_bcd_d;
  logic [3:0]       snap_dp_q,  snap_dp_d;
  logic [DIV_W-1:0] div_q,      div_d;
  logic [1:0]       idx_q,      idx_d;
  logic [6:0]       seg_q,      seg_d;
  logic             dp_out_q,   dp_out_d;
  logic [3:0]       an_q,       an_d;

  logic [3:0]       digit_sel;
  logic [3:0]       digit_zero;
  logic [3:0]       blank_vec;
  logic [6:0]       seg_act;

  // Invalid codes (10..15) show a dash so a corrupted counter is visible.
  function automatic logic [6:0] decode7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  // Snapshot capture and prescaler / digit index advance.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    snap_bcd_d = snap_bcd_q;
    snap_dp_d  = snap_dp_q;
    div_d      = div_q;
    idx_d      = idx_q;
    if (bus.latch) begin
      snap_bcd_d = bus.bcd;
      snap_dp_d  = bus.dp;
    end
    if (bus.en) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        idx_d = idx_q + 2'd1;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  // Decode the selected snapshot digit with leading-zero blanking.
  always_comb begin
    digit_sel = snap_bcd_q[{idx_q, 2'b00} +: 4];
    for (int k = 0; k < 4; k++) begin
      digit_zero[k] = (snap_bcd_q[4*k +: 4] == 4'd0);
    end
    // Digit k blanks only if it and every more-significant digit are zero;
    // digit 0 always shows so an all-zero value reads "0".
    blank_vec = {digit_zero[3],
                 digit_zero[3] & digit_zero[2],
                 digit_zero[3] & digit_zero[2] & digit_zero[1],
                 1'b0} & {4{bus.blank_lz}};
    seg_act   = blank_vec[idx_q] ? 7'h00 : decode7(digit_sel);
    seg_d     = seg_act ^ SEG_INV;
    an_d      = (4'b0001 << idx_q) ^ AN_INV;
    dp_out_d  = snap_dp_q[idx_q] ^ COMMON_ANODE;
  end

  // State and output registers; clr wins over latch, en and scan progress.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (clr) begin
      snap_bcd_q <= '0;
      snap_dp_q  <= '0;
      div_q      <= '0;
      idx_q      <= '0;
      seg_q      <= SEG_INV;
      an_q       <= AN_INV;
      dp_out_q   <= COMMON_ANODE;
    end else begin
      snap_bcd_q <= snap_bcd_d;
      snap_dp_q  <= snap_dp_d;
      div_q      <= div_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      dp_out_q   <= dp_out_d;
    end
  end

  assign bus.seg       = seg_q;
  assign bus.an        = an_q;
  assign bus.dp_out    = dp_out_q;
  assign bus.digit_idx = idx_q;

endmodule

// File: tb/tb_seg7_scan4.sv
// Directed bench for seg7_scan4: a common-anode SCAN_DIV=4 instance covers
// reset, scanning, blanking, latch/tick collision, freeze and mid-scan clear;
// a common-cathode SCAN_DIV=1 instance covers the per-cycle scan.
module tb_seg7_scan4;

  logic clk = 1'b0;
  logic clr0;
  logic clr1;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  seg7_scan4_if if0 ();
  seg7_scan4_if if1 ();

  seg7_scan4 #(.SCAN_DIV(4), .COMMON_ANODE(1'b1)) u_dut0 (
    .clk (clk),
    .clr (clr0),
    .bus (if0.slave)
  );

  seg7_scan4 #(.SCAN_DIV(1), .COMMON_ANODE(1'b0)) u_dut1 (
    .clk (clk),
    .clr (clr1),
    .bus (if1.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns just after the edge on which dut0's digit_idx becomes k.
  task automatic wait_idx(input logic [1:0] k);
    int n = 0;
    while (if0.digit_idx == k && n < 40) begin tick(); n++; end
    while (if0.digit_idx != k && n < 40) begin tick(); n++; end
    tests_run++;
    if (n >= 40) begin
      tests_failed++;
      $display("FAIL wait_idx: digit_idx=%0d never reached %0d", if0.digit_idx, k);
    end
  endtask

  task automatic test_reset();
    clr0 = 1'b1;
    tick();
    tick();
    tests_run++;
    if ({if0.seg, if0.an, if0.dp_out, if0.digit_idx} !== {7'h7F, 4'hF, 1'b1, 2'd0}) begin
      tests_failed++;
      $display("FAIL reset_hold: seg=%h an=%h dp=%b idx=%0d, want 7f f 1 0",
               if0.seg, if0.an, if0.dp_out, if0.digit_idx);
    end
    clr0 = 1'b0;
    tick();
    tests_run++;
    if ({if0.seg, if0.an, if0.dp_out} !== {7'h40, 4'hE, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_release: seg=%h an=%h dp=%b, want 40 e 1",
               if0.seg, if0.an, if0.dp_out);
    end
    for (int n = 2; n <= 16; n++) begin
      tick();
      tests_run++;
      if (if0.digit_idx !== 2'((n / 4) % 4)) begin
        tests_failed++;
        $display("FAIL idx_step cycle %0d: idx=%0d want %0d", n, if0.digit_idx, (n / 4) % 4);
      end
    end
  endtask

  task automatic test_scan();
    logic [6:0] exp_seg [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    logic [3:0] exp_an  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic       exp_dp  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    if0.bcd = 16'h1234;
    if0.dp  = 4'b0100;
    if0.latch = 1'b1;
    tick();
    if0.latch = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_idx(2'(k));
      tick();
      tests_run++;
      if ({if0.seg, if0.an, if0.dp_out} !== {exp_seg[k], exp_an[k], exp_dp[k]}) begin
        tests_failed++;
        $display("FAIL scan_1234 digit %0d: seg=%h an=%h dp=%b, want %h %h %b",
                 k, if0.seg, if0.an, if0.dp_out, exp_seg[k], exp_an[k], exp_dp[k]);
      end
    end
  endtask

  task automatic test_blanking();
    logic [6:0] exp_bl [4] = '{7'h40, 7'h78, 7'h7F, 7'h7F};
    if0.bcd = 16'h0070;
    if0.dp  = 4'b0000;
    if0.blank_lz = 1'b1;
    if0.latch = 1'b1;
    tick();
    if0.latch = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_idx(2'(k));
      tick();
      tests_run++;
      if ({if0.seg, if0.an} !== {exp_bl[k], 4'((4'b0001 << k) ^ 4'hF)}) begin
        tests_failed++;
        $display("FAIL blank_lz1 digit %0d: seg=%h an=%h, want %h with anode driven",
                 k, if0.seg, if0.an, exp_bl[k]);
      end
    end
    if0.blank_lz = 1'b0;
    for (int k = 2; k < 4; k++) begin
      wait_idx(2'(k));
      tick();
      tests_run++;
      if (if0.seg !== 7'h40) begin
        tests_failed++;
        $display("FAIL blank_lz0 digit %0d: seg=%h want 40", k, if0.seg);
      end
    end
  endtask

  task automatic test_collision();
    if0.bcd = 16'hA000;
    if0.dp  = 4'b0000;
    wait_idx(2'd2);
    tick();
    tick();
    tick();
    tests_run++;
    if (if0.digit_idx !== 2'd2) begin
      tests_failed++;
      $display("FAIL pre_tick idx: idx=%0d want 2", if0.digit_idx);
    end
    if0.latch = 1'b1;
    tick();
    if0.latch = 1'b0;
    tests_run++;
    if (if0.digit_idx !== 2'd3) begin
      tests_failed++;
      $display("FAIL tick_idx: idx=%0d want 3", if0.digit_idx);
    end
    tick();
    tests_run++;
    if ({if0.seg, if0.an, if0.dp_out} !== {7'h3F, 4'h7, 1'b1}) begin
      tests_failed++;
      $display("FAIL latch_tick: seg=%h an=%h dp=%b, want 3f 7 1",
               if0.seg, if0.an, if0.dp_out);
    end
  endtask

  task automatic test_freeze_and_clear();
    wait_idx(2'd1);
    tick();
    tick();
    if0.en = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      tests_run++;
      if ({if0.digit_idx, if0.seg, if0.an, if0.dp_out} !== {2'd1, 7'h40, 4'hD, 1'b1}) begin
        tests_failed++;
        $display("FAIL freeze cycle %0d: idx=%0d seg=%h an=%h dp=%b, want 1 40 d 1",
                 n, if0.digit_idx, if0.seg, if0.an, if0.dp_out);
      end
    end
    if0.en = 1'b1;
    tick();
    tests_run++;
    if (if0.digit_idx !== 2'd1) begin
      tests_failed++;
      $display("FAIL resume_1: idx=%0d want 1", if0.digit_idx);
    end
    tick();
    tests_run++;
    if (if0.digit_idx !== 2'd2) begin
      tests_failed++;
      $display("FAIL resume_2: idx=%0d want 2", if0.digit_idx);
    end
    // Load lit decimal points so the clear visibly wipes the dp snapshot.
    if0.dp = 4'hF;
    if0.latch = 1'b1;
    tick();
    if0.latch = 1'b0;
    wait_idx(2'd3);
    tick();
    tests_run++;
    if (if0.dp_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL dp_lit: dp=%b want 0", if0.dp_out);
    end
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    tests_run++;
    if ({if0.digit_idx, if0.seg, if0.an, if0.dp_out} !== {2'd0, 7'h7F, 4'hF, 1'b1}) begin
      tests_failed++;
      $display("FAIL mid_clr: idx=%0d seg=%h an=%h dp=%b, want 0 7f f 1",
               if0.digit_idx, if0.seg, if0.an, if0.dp_out);
    end
    tick();
    tests_run++;
    if ({if0.digit_idx, if0.seg, if0.an, if0.dp_out} !== {2'd0, 7'h40, 4'hE, 1'b1}) begin
      tests_failed++;
      $display("FAIL post_clr digit0: idx=%0d seg=%h an=%h dp=%b, want 0 40 e 1",
               if0.digit_idx, if0.seg, if0.an, if0.dp_out);
    end
    tick();
    tick();
    tests_run++;
    if (if0.digit_idx !== 2'd0) begin
      tests_failed++;
      $display("FAIL no_partial_dwell: idx=%0d want 0", if0.digit_idx);
    end
    tick();
    tests_run++;
    if (if0.digit_idx !== 2'd1) begin
      tests_failed++;
      $display("FAIL full_dwell: idx=%0d want 1", if0.digit_idx);
    end
    wait_idx(2'd3);
    tick();
    tests_run++;
    if ({if0.seg, if0.dp_out} !== {7'h40, 1'b1}) begin
      tests_failed++;
      $display("FAIL post_clr digit3: seg=%h dp=%b, want 40 1", if0.seg, if0.dp_out);
    end
  endtask

  task automatic test_fast_scan();
    logic [1:0] exp_idx [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0] exp_an  [4] = '{4'h1, 4'h2, 4'h4, 4'h8};
    logic [6:0] exp_seg [4] = '{7'h7D, 7'h07, 7'h7F, 7'h6F};
    tests_run++;
    if ({if1.seg, if1.an, if1.dp_out} !== {7'h00, 4'h0, 1'b0}) begin
      tests_failed++;
      $display("FAIL cc_reset: seg=%h an=%h dp=%b, want 00 0 0",
               if1.seg, if1.an, if1.dp_out);
    end
    clr1 = 1'b0;
    if1.bcd = 16'h9876;
    if1.latch = 1'b1;
    tick();
    if1.latch = 1'b0;
    if1.en = 1'b1;
    tests_run++;
    if ({if1.digit_idx, if1.seg, if1.an} !== {2'd0, 7'h3F, 4'h1}) begin
      tests_failed++;
      $display("FAIL cc_latch: idx=%0d seg=%h an=%h, want 0 3f 1",
               if1.digit_idx, if1.seg, if1.an);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      tests_run++;
      if ({if1.digit_idx, if1.seg, if1.an, if1.dp_out} !== {exp_idx[k], exp_seg[k], exp_an[k], 1'b0}) begin
        tests_failed++;
        $display("FAIL cc_scan step %0d: idx=%0d seg=%h an=%h dp=%b, want %0d %h %h 0",
                 k, if1.digit_idx, if1.seg, if1.an, if1.dp_out, exp_idx[k], exp_seg[k], exp_an[k]);
      end
    end
  endtask

  initial begin
    clr0 = 1'b1;
    clr1 = 1'b1;
    if0.en = 1'b1;  if0.latch = 1'b0; if0.bcd = 16'h0; if0.dp = 4'h0; if0.blank_lz = 1'b0;
    if1.en = 1'b0;  if1.latch = 1'b0; if1.bcd = 16'h0; if1.dp = 4'h0; if1.blank_lz = 1'b0;
    test_reset();
    test_scan();
    test_blanking();
    test_collision();
    test_freeze_and_clear();
    test_fast_scan();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
